// File: rtl/lcd_seq_ctrl.sv
// HD44780 2x16 write-only sequencer: power-up wait, init commands, then full-screen frames
// fetched from an external character source, re-run on each refresh request.
module lcd_seq_ctrl #(
  parameter int unsigned TICK_DIV    = 8,
  parameter int unsigned POWER_STEPS = 2,
  parameter int unsigned CLR_WAIT    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       refresh_req,
  output logic [4:0] char_addr,
  input  logic [7:0] char_data,
  output logic       busy,
  output logic       refresh_ack,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data
);

  localparam int unsigned DivW = $clog2(TICK_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);
  localparam logic [DivW-1:0] DivPre  = DivW'(TICK_DIV - 2);
  localparam logic [DivW-1:0] EOnPre  = DivW'(1);
  localparam logic [DivW-1:0] EOffPre = DivW'(TICK_DIV / 2);
  localparam logic [5:0] PwrLast   = 6'(POWER_STEPS - 1);
  localparam logic [5:0] ClrLast   = 6'(CLR_WAIT - 1);
  localparam logic [5:0] FrameLast = 6'd33;

  typedef enum logic [2:0] {StPwrWait, StInit, StClrWait, StIdle, StFrame} state_e;

  state_e          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [DivW-1:0] div_q;
  logic            pending_q;
  logic            boundary, leave_idle, e_window, addr_load;
  logic [4:0]      addr_next;
  logic            nxt_rs;
  logic [7:0]      nxt_data;

  assign lcd_rw     = 1'b0;
  assign boundary   = (div_q == DivLast);
  assign leave_idle = boundary && (state_q == StIdle) && pending_q;
  assign e_window   = ((state_q == StInit) || (state_q == StFrame)) &&
                      (div_q >= EOnPre) && (div_q <= EOffPre);

  // char_addr is set one cycle before the boundary so char_data is settled when lcd_data loads.
  assign addr_load = (div_q == DivPre) && (state_q == StFrame) &&
                     (cnt_q != 6'd16) && (cnt_q != FrameLast);
  assign addr_next = (cnt_q < 6'd16) ? cnt_q[4:0] : (cnt_q[4:0] - 5'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 6'd1;
    unique case (state_q)
      StPwrWait: if (cnt_q == PwrLast) begin
        state_d = StInit;
        cnt_d   = '0;
      end
      StInit: begin
        if (cnt_q == 6'd2 && CLR_WAIT != 0) begin
          state_d = StClrWait;
          cnt_d   = '0;
        end else if (cnt_q == 6'd3) begin
          state_d = StFrame;
          cnt_d   = '0;
        end
      end
      StClrWait: if (cnt_q == ClrLast) begin
        state_d = StInit;
        cnt_d   = 6'd3;
      end
      StIdle: begin
        cnt_d = cnt_q;
        if (pending_q) begin
          state_d = StFrame;
          cnt_d   = '0;
        end
      end
      StFrame: if (cnt_q == FrameLast) begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StPwrWait;
        cnt_d   = '0;
      end
    endcase
  end

  // Bus contents of the step about to start.
  always_comb begin
    nxt_rs   = 1'b0;
    nxt_data = 8'h00;
    case (state_d)
      StInit: begin
        case (cnt_d)
          6'd0:    nxt_data = 8'h38;
          6'd1:    nxt_data = 8'h0C;
          6'd2:    nxt_data = 8'h01;
          default: nxt_data = 8'h06;
        endcase
      end
      StFrame: begin
        if (cnt_d == 6'd0) begin
          nxt_data = 8'h80;
        end else if (cnt_d == 6'd17) begin
          nxt_data = 8'hC0;
        end else begin
          nxt_rs   = 1'b1;
          nxt_data = char_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StPwrWait;
      cnt_q       <= '0;
      div_q       <= '0;
      pending_q   <= 1'b0;
      lcd_e       <= 1'b0;
      lcd_rs      <= 1'b0;
      lcd_data    <= 8'h00;
      char_addr   <= 5'd0;
      busy        <= 1'b0;
      refresh_ack <= 1'b0;
    end else begin
      div_q       <= boundary ? '0 : div_q + 1'b1;
      pending_q   <= refresh_req | (pending_q & ~leave_idle);
      lcd_e       <= e_window;
      refresh_ack <= boundary && (state_q == StFrame) && (cnt_q == FrameLast);
      busy        <= ((boundary ? state_d : state_q) != StIdle);
      if (addr_load) begin
        char_addr <= addr_next;
      end
      if (boundary) begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        lcd_rs   <= nxt_rs;
        lcd_data <= nxt_data;
      end
    end
  end

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Scoreboard bench for lcd_seq_ctrl: expected bus writes and ack cycles are queued by the
// stimulus thread and consumed by a negedge monitor.
module tb_lcd_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       refresh_req = 1'b0;
  logic [4:0] char_addr;
  logic [7:0] char_data;
  logic       busy, refresh_ack, lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;

  lcd_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .refresh_req(refresh_req),
    .char_addr  (char_addr),
    .char_data  (char_data),
    .busy       (busy),
    .refresh_ack(refresh_ack),
    .lcd_e      (lcd_e),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_data   (lcd_data)
  );

  assign char_data = 8'h40 + {3'b000, char_addr};

  always #5 clk = ~clk;

  int         cyc;
  int         checks = 0;
  int         failures = 0;
  logic [8:0] bus_q[$];
  int         ack_q[$];
  logic       prev_e = 1'b0;
  logic [8:0] prev_bus = '0;
  int         first_e = -1;
  int         ack_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_init();
    bus_q.push_back({1'b0, 8'h38});
    bus_q.push_back({1'b0, 8'h0C});
    bus_q.push_back({1'b0, 8'h01});
    bus_q.push_back({1'b0, 8'h06});
  endtask

  task automatic push_frame();
    bus_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 16; i++) bus_q.push_back({1'b1, 8'(8'h40 + i)});
    bus_q.push_back({1'b0, 8'hC0});
    for (int i = 16; i < 32; i++) bus_q.push_back({1'b1, 8'(8'h40 + i)});
  endtask

  task automatic wait_cyc(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic pulse_at(input int k);
    wait_cyc(k);
    refresh_req = 1'b1;
    @(negedge clk);
    refresh_req = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((bus_q.size() != 0 || ack_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", bus_q.size() + ack_q.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_e"}, lcd_e, 0);
    chk({tag, "_rs"}, lcd_rs, 0);
    chk({tag, "_rw"}, lcd_rw, 0);
    chk({tag, "_data"}, lcd_data, 0);
    chk({tag, "_addr"}, char_addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ack"}, refresh_ack, 0);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Monitor: bus write is taken at each lcd_e falling edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_e  = 1'b0;
      first_e = -1;
    end else begin
      chk("lcd_rw", lcd_rw, 0);
      if (lcd_e && first_e < 0) first_e = cyc;
      if (prev_e && lcd_e) chk("bus_stable", {lcd_rs, lcd_data}, prev_bus);
      if (prev_e && !lcd_e) begin
        if (bus_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL bus_extra: got %0h expected no write (cycle %0d)", prev_bus, cyc);
        end else begin
          chk("bus_write", prev_bus, bus_q.pop_front());
        end
      end
      if (refresh_ack) begin
        ack_seen++;
        if (ack_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL ack_extra: got ack at cycle %0d expected none", cyc);
        end else begin
          chk("ack_cycle", cyc, ack_q.pop_front());
        end
      end
      prev_e   = lcd_e;
      prev_bus = {lcd_rs, lcd_data};
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");

    // Power-up: init sequence and automatic first frame.
    @(negedge clk);
    push_init();
    push_frame();
    ack_q.push_back(336);
    rst = 1'b0;
    wait_drain(600);
    chk("first_e_cycle", first_e, 18);
    wait_cyc(340);
    chk("idle_busy", busy, 0);
    chk("idle_e", lcd_e, 0);
    chk("idle_data", lcd_data, 0);

    // Single request from IDLE; frame starts at the next boundary (cycle 351).
    pulse_at(347);
    push_frame();
    ack_q.push_back(624);
    wait_cyc(351);
    chk("busy_before_start", busy, 0);
    wait_cyc(352);
    chk("busy_at_start", busy, 1);

    // Three requests mid-frame collapse into one extra frame.
    push_frame();
    ack_q.push_back(904);
    pulse_at(397);
    pulse_at(447);
    pulse_at(547);

    // Request on the final boundary cycle: one IDLE step, then another frame.
    push_frame();
    ack_q.push_back(1184);
    pulse_at(903);
    wait_drain(1500);
    chk("ack_total", ack_seen, 4);
    wait_cyc(1480);
    chk("no_stray_ack", ack_seen, 4);
    chk("idle_busy2", busy, 0);

    // Reset during the data step for char_addr 7 aborts the frame.
    bus_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 7; i++) bus_q.push_back({1'b1, 8'(8'h40 + i)});
    pulse_at(1491);
    wait_cyc(1562);
    chk("abort_addr", char_addr, 7);
    chk("abort_e", lcd_e, 1);
    chk("abort_rs", lcd_rs, 1);
    chk("abort_drain", bus_q.size(), 0);
    #1 rst = 1'b1;
    #1;
    chk_all_zero("async_reset");
    repeat (2) @(negedge clk);
    push_init();
    push_frame();
    ack_q.push_back(336);
    rst = 1'b0;
    wait_drain(600);
    chk("first_e_rerun", first_e, 18);
    chk("ack_total_final", ack_seen, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
